// File: rtl/apb_host_bridge.sv
// apb_host_bridge: single-outstanding valid/ready command to APB3/APB4 bridge.
// Each accepted command runs as one APB transfer. The read data and status are
// returned on a valid/ready response channel. An optional ACCESS-phase timeout
// aborts transfers to a slave that never raises PREADY.
module apb_host_bridge #(
   parameter int ADDRESS_WIDTH  = 7,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_write,
   input  logic [ADDRESS_WIDTH-1:0]   i_req_address,
   input  logic [BUS_WIDTH-1:0]       i_req_write_data,
   input  logic [BUS_WIDTH/8-1:0]     i_req_strobe,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [BUS_WIDTH-1:0]       o_rsp_read_data,
   output logic [1:0]                 o_rsp_status,
   output logic                       o_psel,
   output logic                       o_penable,
   output logic                       o_pwrite,
   output logic [ADDRESS_WIDTH-1:0]   o_paddr,
   output logic [BUS_WIDTH-1:0]       o_pwdata,
   output logic [BUS_WIDTH/8-1:0]     o_pstrb,
   input  logic                       i_pready,
   input  logic                       i_pslverr,
   input  logic [BUS_WIDTH-1:0]       i_prdata
);

   localparam int STRB_W     = BUS_WIDTH / 8;
   localparam int ALIGN_BITS = $clog2(STRB_W);
   localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
      ~ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);

   localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESPONSE
   } state_t;

   state_t                     state;
   state_t                     state_next;

   logic                       lat_write;
   logic [ADDRESS_WIDTH-1:0]   lat_addr;
   logic [BUS_WIDTH-1:0]       lat_wdata;
   logic [STRB_W-1:0]          lat_strb;
   logic [BUS_WIDTH-1:0]       rsp_rdata;
   logic [1:0]                 rsp_status;
   logic [CNT_W-1:0]           wait_count;
   logic                       timeout_hit;

   // Final ACCESS cycle of the timeout window; PREADY in this cycle still wins.
   assign timeout_hit = TIMEOUT_EN && (wait_count == CNT_LAST);

   // State register; reset drops any transfer or pending response.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one SETUP cycle, ACCESS until PREADY or timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (i_req_valid) state_next = SETUP;
         SETUP:    state_next = ACCESS;
         ACCESS:   if (i_pready || timeout_hit) state_next = RESPONSE;
         RESPONSE: if (i_rsp_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Output decode; APB bus fields are only driven while the transfer is active.
   always_comb begin
      o_req_ready     = 1'b0;
      o_rsp_valid     = 1'b0;
      o_rsp_read_data = '0;
      o_rsp_status    = '0;
      o_psel          = 1'b0;
      o_penable       = 1'b0;
      o_pwrite        = 1'b0;
      o_paddr         = '0;
      o_pwdata        = '0;
      o_pstrb         = '0;
      case (state)
         IDLE: begin
            // Ready stays low while reset is held so every output reads 0.
            o_req_ready = ~i_rst;
         end
         SETUP, ACCESS: begin
            o_psel    = 1'b1;
            o_penable = (state == ACCESS);
            o_pwrite  = lat_write;
            o_paddr   = lat_addr;
            o_pwdata  = lat_wdata;
            o_pstrb   = lat_strb;
         end
         RESPONSE: begin
            o_rsp_valid     = 1'b1;
            o_rsp_read_data = rsp_rdata;
            o_rsp_status    = rsp_status;
         end
         default: ;
      endcase
   end

   // Command capture, ACCESS wait counter and response capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_strb   <= '0;
         rsp_rdata  <= '0;
         rsp_status <= '0;
         wait_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  lat_write <= i_req_write;
                  lat_addr  <= i_req_address & ADDR_MASK;
                  lat_wdata <= i_req_write_data;
                  lat_strb  <= i_req_write ? i_req_strobe : '0;
               end
            end
            SETUP: begin
               wait_count <= '0;
            end
            ACCESS: begin
               if (i_pready) begin
                  rsp_rdata  <= lat_write ? '0 : i_prdata;
                  rsp_status <= {i_pslverr, 1'b0};
               end else begin
                  wait_count <= wait_count + CNT_W'(1);
                  if (timeout_hit) begin
                     rsp_rdata  <= '0;
                     rsp_status <= STATUS_TIMEOUT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_host_bridge.sv
// Scoreboard bench for apb_host_bridge: the stimulus pushes expected responses,
// and a monitor compares them while the DUT presents o_rsp_valid.
module tb_apb_host_bridge;

   logic        i_clk;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [6:0]  i_req_address;
   logic [31:0] i_req_write_data;
   logic [3:0]  i_req_strobe;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_read_data;
   logic [1:0]  o_rsp_status;
   logic        o_psel;
   logic        o_penable;
   logic        o_pwrite;
   logic [6:0]  o_paddr;
   logic [31:0] o_pwdata;
   logic [3:0]  o_pstrb;
   logic        i_pready;
   logic        i_pslverr;
   logic [31:0] i_prdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];

   apb_host_bridge #(
      .ADDRESS_WIDTH (7),
      .BUS_WIDTH     (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_write     (i_req_write),
      .i_req_address   (i_req_address),
      .i_req_write_data(i_req_write_data),
      .i_req_strobe    (i_req_strobe),
      .o_rsp_valid     (o_rsp_valid),
      .i_rsp_ready     (i_rsp_ready),
      .o_rsp_read_data (o_rsp_read_data),
      .o_rsp_status    (o_rsp_status),
      .o_psel          (o_psel),
      .o_penable       (o_penable),
      .o_pwrite        (o_pwrite),
      .o_paddr         (o_paddr),
      .o_pwdata        (o_pwdata),
      .o_pstrb         (o_pstrb),
      .i_pready        (i_pready),
      .i_pslverr       (i_pslverr),
      .i_prdata        (i_prdata)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required end before 200000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got bound expired required DUT event", name);
   endtask

   // Monitor: compares every cycle the response is presented, pops on handshake.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_rsp");
            end else begin
               chk("rsp", {o_rsp_read_data, o_rsp_status}, exp_q[0]);
               if (i_rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   // Issue one command, act as the APB slave, and measure accept-to-response cycles.
   // Returns at the negedge of the first response cycle.
   task automatic run_txn(
      input  logic        wr,
      input  logic [6:0]  addr,
      input  logic [31:0] wd,
      input  logic [3:0]  strb,
      input  int          waits,
      input  logic        hang,
      input  logic        err,
      input  logic [31:0] rd,
      input  logic [6:0]  exp_paddr,
      input  logic [3:0]  exp_pstrb,
      input  logic [31:0] exp_rd,
      input  logic [1:0]  exp_st,
      input  int          exp_lat,
      output int          acc_cycles
   );
      int lat;
      bit acc;
      bit got;
      exp_q.push_back({exp_rd, exp_st});
      i_req_valid      = 1'b1;
      i_req_write      = wr;
      i_req_address    = addr;
      i_req_write_data = wd;
      i_req_strobe     = strb;
      acc        = 1'b0;
      acc_cycles = 0;
      while (!acc && acc_cycles < 40) begin
         acc_cycles++;
         @(negedge i_clk);
         acc = o_req_ready;
         next_cycle();
      end
      i_req_valid = 1'b0;
      if (!acc) begin
         fail_now("accept");
         return;
      end
      @(negedge i_clk);
      chk("setup_ctl", {o_psel, o_penable, o_pwrite, o_rsp_valid, o_req_ready},
          {1'b1, 1'b0, wr, 1'b0, 1'b0});
      chk("setup_bus", {o_paddr, o_pstrb, o_pwdata}, {exp_paddr, exp_pstrb, wd});
      next_cycle();
      got = 1'b0;
      lat = 2;
      while (!got && lat < 40) begin
         i_pready  = !hang && ((lat - 2) >= waits);
         i_pslverr = i_pready & err;
         i_prdata  = i_pready ? rd : 32'hDEAD_BEEF;
         @(negedge i_clk);
         if (o_rsp_valid) begin
            got = 1'b1;
         end else begin
            chk("access", {o_psel, o_penable, o_pwrite, o_paddr, o_pstrb, o_pwdata, o_req_ready},
                {2'b11, wr, exp_paddr, exp_pstrb, wd, 1'b0});
            next_cycle();
            lat++;
         end
      end
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      i_prdata  = '0;
      if (!got) fail_now("rsp_latency");
      else chk("rsp_latency", lat, exp_lat);
      chk("rsp_apb_idle", {o_psel, o_penable, o_req_ready}, 3'b000);
   endtask

   initial begin
      int ac;
      i_rst            = 1'b1;
      i_req_valid      = 1'b0;
      i_req_write      = 1'b0;
      i_req_address    = '0;
      i_req_write_data = '0;
      i_req_strobe     = '0;
      i_rsp_ready      = 1'b1;
      i_pready         = 1'b0;
      i_pslverr        = 1'b0;
      i_prdata         = '0;
      #1;
      chk("reset_ctl", {o_req_ready, o_rsp_valid, o_rsp_status, o_psel, o_penable, o_pwrite, o_pstrb}, '0);
      chk("reset_data", {o_rsp_read_data, o_pwdata}, '0);
      chk("reset_addr", o_paddr, '0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("reset_release_ready", {o_req_ready, o_psel, o_rsp_valid}, 3'b100);
      next_cycle();

      // Write, no wait states
      run_txn(1'b1, 7'h40, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 1'b0, 32'h1111_1111,
              7'h40, 4'hF, 32'h0, 2'b00, 3, ac);
      next_cycle();
      // Read, unaligned address, two wait states
      run_txn(1'b0, 7'h05, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'h1234_5678,
              7'h04, 4'h0, 32'h1234_5678, 2'b00, 5, ac);
      next_cycle();
      // Write with slave error; read data must stay 0
      run_txn(1'b1, 7'h08, 32'h0F0F_0F0F, 4'h3, 1, 1'b0, 1'b1, 32'hFFFF_FFFF,
              7'h08, 4'h3, 32'h0, 2'b10, 4, ac);
      next_cycle();
      // Read timeout
      run_txn(1'b0, 7'h0C, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h0,
              7'h0C, 4'h0, 32'h0, 2'b11, 6, ac);
      next_cycle();
      // PREADY in the final timeout cycle wins
      run_txn(1'b0, 7'h1F, 32'h0, 4'h0, 3, 1'b0, 1'b0, 32'h89AB_CDEF,
              7'h1C, 4'h0, 32'h89AB_CDEF, 2'b00, 6, ac);
      next_cycle();
      // Read with slave error keeps captured data
      run_txn(1'b0, 7'h43, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0BAD_0BAD,
              7'h40, 4'h0, 32'h0BAD_0BAD, 2'b10, 3, ac);
      next_cycle();
      // Write timeout
      run_txn(1'b1, 7'h22, 32'h7654_3210, 4'h5, 0, 1'b1, 1'b0, 32'h0,
              7'h20, 4'h5, 32'h0, 2'b11, 6, ac);
      next_cycle();

      // Response backpressure with a pending request
      i_rsp_ready = 1'b0;
      run_txn(1'b0, 7'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'hCAFE_F00D,
              7'h10, 4'h0, 32'hCAFE_F00D, 2'b00, 3, ac);
      next_cycle();
      i_req_valid      = 1'b1;
      i_req_write      = 1'b1;
      i_req_address    = 7'h44;
      i_req_write_data = 32'h1122_3344;
      i_req_strobe     = 4'hC;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("bp_hold", {o_req_ready, o_rsp_valid, o_psel}, 3'b010);
         next_cycle();
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      chk("bp_handshake_cycle", {o_req_ready, o_rsp_valid}, 2'b01);
      next_cycle();
      run_txn(1'b1, 7'h44, 32'h1122_3344, 4'hC, 0, 1'b0, 1'b0, 32'h0,
              7'h44, 4'hC, 32'h0, 2'b00, 3, ac);
      chk("bp_accept_delay", ac, 1);
      next_cycle();

      // Asynchronous reset in the middle of ACCESS
      i_req_valid   = 1'b1;
      i_req_write   = 1'b0;
      i_req_address = 7'h30;
      @(negedge i_clk);
      chk("rst_pre_ready", o_req_ready, 1'b1);
      next_cycle();
      i_req_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge i_clk);
      chk("rst_pre_access", {o_psel, o_penable}, 2'b11);
      next_cycle();
      #2;
      i_rst = 1'b1;
      #1;
      chk("rst_async", {o_psel, o_penable, o_rsp_valid, o_req_ready}, 4'b0000);
      @(negedge i_clk);
      next_cycle();
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_release", {o_req_ready, o_psel, o_penable, o_rsp_valid}, 4'b1000);
      next_cycle();

      // Recovery after reset
      run_txn(1'b0, 7'h7E, 32'h0, 4'h0, 1, 1'b0, 1'b0, 32'h55AA_55AA,
              7'h7C, 4'h0, 32'h55AA_55AA, 2'b00, 4, ac);
      next_cycle();
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
